// File: rtl/cache_line_transfer_if.sv
// Request, data-memory and narrow-bus signals of the cache line-transfer engine.
// The engine connects through the master modport; its environment uses slave.
interface cache_line_transfer_if #(
  parameter int AINDEX_WIDTH   = 3,
  parameter int CH_NUM_WIDTH   = 2,
  parameter int CASH_MEM_WIDTH = 128,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wb;
  logic                      req_fill;
  logic [AINDEX_WIDTH-1:0]   req_index;
  logic [CH_NUM_WIDTH-1:0]   req_chan;
  logic [ADDR_WIDTH-1:0]     req_wb_addr;
  logic [ADDR_WIDTH-1:0]     req_fill_addr;
  logic                      done;
  logic                      err;
  logic [AINDEX_WIDTH-1:0]   dm_index;
  logic [CH_NUM_WIDTH-1:0]   dm_chan;
  logic                      dm_wr;
  logic [CASH_MEM_WIDTH-1:0] dm_data_in;
  logic [CASH_MEM_WIDTH-1:0] dm_data_out;
  logic                      bus_valid;
  logic                      bus_wr;
  logic [ADDR_WIDTH-1:0]     bus_addr;
  logic [BUS_WIDTH-1:0]      bus_wdata;
  logic                      bus_ready;
  logic [BUS_WIDTH-1:0]      bus_rdata;

  modport master (
    input  req_valid, req_wb, req_fill, req_index, req_chan, req_wb_addr, req_fill_addr,
    input  dm_data_out, bus_ready, bus_rdata,
    output req_ready, done, err, dm_index, dm_chan, dm_wr, dm_data_in,
    output bus_valid, bus_wr, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_wb, req_fill, req_index, req_chan, req_wb_addr, req_fill_addr,
    output dm_data_out, bus_ready, bus_rdata,
    input  req_ready, done, err, dm_index, dm_chan, dm_wr, dm_data_in,
    input  bus_valid, bus_wr, bus_addr, bus_wdata
  );
endinterface

// File: rtl/cache_line_transfer.sv
// Moves one cache line between the data memory and a narrow bus: optional write-back, then optional fill.
// Optional per-beat bus timeout is enabled with `define LINE_XFER_TIMEOUT_EN.
module cache_line_transfer #(
  parameter int AINDEX_WIDTH   = 3,
  parameter int CH_NUM_WIDTH   = 2,
  parameter int CASH_MEM_WIDTH = 128,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT        = 255
) (
  input logic                   clk,
  input logic                   reset,
  cache_line_transfer_if.master xif
);

  localparam int BEATS  = CASH_MEM_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BUS_WIDTH / 8);

  if ((CASH_MEM_WIDTH % BUS_WIDTH) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("cache_line_transfer: line width must be a multiple of the bus width and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {IDLE, WB_LOAD, WB_BEAT, FILL_BEAT, FILL_WRITE, DONE} state_t;

  state_t                    state;
  logic [BEAT_W-1:0]         beat;
  logic [BEAT_W-1:0]         beat_nxt;
  logic [CASH_MEM_WIDTH-1:0] line_buf;
  logic [CASH_MEM_WIDTH-1:0] fill_merged;
  logic                      fill_q;
  logic [ADDR_WIDTH-1:0]     fill_addr_q;
  logic                      abort;

  logic                      req_ready_q;
  logic                      done_q;
  logic                      err_q;
  logic [AINDEX_WIDTH-1:0]   dm_index_q;
  logic [CH_NUM_WIDTH-1:0]   dm_chan_q;
  logic                      dm_wr_q;
  logic [CASH_MEM_WIDTH-1:0] dm_data_in_q;
  logic                      bus_valid_q;
  logic                      bus_wr_q;
  logic [ADDR_WIDTH-1:0]     bus_addr_q;
  logic [BUS_WIDTH-1:0]      bus_wdata_q;

  assign beat_nxt = beat + BEAT_W'(1);

  // Line buffer with the current read beat already merged in, so the last beat can go straight to memory.
  always_comb begin
    fill_merged = line_buf;
    fill_merged[int'(beat)*BUS_WIDTH +: BUS_WIDTH] = xif.bus_rdata;
  end

`ifdef LINE_XFER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Counts consecutive stalled cycles of the current beat; any completed or idle cycle restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (bus_valid_q && !xif.bus_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign abort = bus_valid_q && !xif.bus_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      line_buf     <= '0;
      fill_q       <= 1'b0;
      fill_addr_q  <= '0;
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dm_index_q   <= '0;
      dm_chan_q    <= '0;
      dm_wr_q      <= 1'b0;
      dm_data_in_q <= '0;
      bus_valid_q  <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      dm_wr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (xif.req_valid) begin
            req_ready_q <= 1'b0;
            dm_index_q  <= xif.req_index;
            dm_chan_q   <= xif.req_chan;
            fill_q      <= xif.req_fill;
            fill_addr_q <= xif.req_fill_addr;
            beat        <= '0;
            if (xif.req_wb) begin
              state      <= WB_LOAD;
              bus_addr_q <= xif.req_wb_addr;
            end else if (xif.req_fill) begin
              state       <= FILL_BEAT;
              bus_valid_q <= 1'b1;
              bus_wr_q    <= 1'b0;
              bus_addr_q  <= xif.req_fill_addr;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        WB_LOAD: begin
          line_buf    <= xif.dm_data_out;
          bus_wdata_q <= xif.dm_data_out[BUS_WIDTH-1:0];
          bus_valid_q <= 1'b1;
          bus_wr_q    <= 1'b1;
          state       <= WB_BEAT;
        end
        WB_BEAT: begin
          if (abort) begin
            state       <= DONE;
            bus_valid_q <= 1'b0;
            bus_wr_q    <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
          end else if (xif.bus_ready) begin
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (fill_q) begin
                state      <= FILL_BEAT;
                bus_wr_q   <= 1'b0;
                bus_addr_q <= fill_addr_q;
              end else begin
                state       <= DONE;
                bus_valid_q <= 1'b0;
                bus_wr_q    <= 1'b0;
                done_q      <= 1'b1;
              end
            end else begin
              beat        <= beat_nxt;
              bus_addr_q  <= bus_addr_q + BEAT_BYTES;
              bus_wdata_q <= line_buf[int'(beat_nxt)*BUS_WIDTH +: BUS_WIDTH];
            end
          end
        end
        FILL_BEAT: begin
          if (abort) begin
            state       <= DONE;
            bus_valid_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
          end else if (xif.bus_ready) begin
            line_buf <= fill_merged;
            if (beat == LAST_BEAT) begin
              beat         <= '0;
              state        <= FILL_WRITE;
              bus_valid_q  <= 1'b0;
              dm_wr_q      <= 1'b1;
              dm_data_in_q <= fill_merged;
            end else begin
              beat       <= beat_nxt;
              bus_addr_q <= bus_addr_q + BEAT_BYTES;
            end
          end
        end
        FILL_WRITE: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          err_q       <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign xif.req_ready  = req_ready_q;
  assign xif.done       = done_q;
  assign xif.err        = err_q;
  assign xif.dm_index   = dm_index_q;
  assign xif.dm_chan    = dm_chan_q;
  assign xif.dm_wr      = dm_wr_q;
  assign xif.dm_data_in = dm_data_in_q;
  assign xif.bus_valid  = bus_valid_q;
  assign xif.bus_wr     = bus_wr_q;
  assign xif.bus_addr   = bus_addr_q;
  assign xif.bus_wdata  = bus_wdata_q;

endmodule
